// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle logic/shift/add ops plus iterative
// shift-add multiply and restoring divide, one result per valid/ready transfer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | empty, in_ready=1, waiting for a request
// ST_BUSY   | iterating MUL/MULHU/DIVU/REMU, one step per cycle, N cycles
// ST_DONE   | result held with out_valid=1 until consumed
module alu_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    localparam int S = $clog2(N);
    localparam logic [S-1:0] CNT_LAST = S'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b1100;
    localparam logic [3:0] OP_SLT   = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;
    localparam logic [3:0] OP_SLTU  = 4'b1111;

    logic [1:0]   state_q, state_d;
    logic [S-1:0] cnt_q, cnt_d;
    logic [3:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] lo_q, lo_d;
    logic [N-1:0] result_q, result_d;
    logic         overflow_q, overflow_d;
    logic         zero_q, zero_d;
    logic         equal_q, equal_d;

    logic accept, consume;
    logic in_is_mc, in_is_mul, op_is_div;

    logic [N-1:0] sc_res, sum_v, diff_v, sra_v;
    logic         sc_ovf, shamt_big;
    logic [S-1:0] shamt;

    logic [N:0]   mul_sum;
    logic [N:0]   div_shift;
    logic [N-1:0] div_sub;
    logic         div_ge;
    logic [N-1:0] step_hi, step_lo, mc_res;

    always_comb begin
        in_ready  = rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        out_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        in_is_mul = (control == OP_MUL) || (control == OP_MULHU);
        in_is_mc  = in_is_mul || (control == OP_DIVU) || (control == OP_REMU);
        op_is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
    end

    // Single-cycle ops evaluate straight from the request so they land on accept.
    always_comb begin
        shamt     = b[S-1:0];
        shamt_big = |b[N-1:S];
        sum_v     = a + b;
        diff_v    = a - b;
        sra_v     = $signed(a) >>> shamt;
        sc_res    = '0;
        sc_ovf    = 1'b0;
        case (control)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLL:  sc_res = shamt_big ? '0 : (a << shamt);
            OP_SRL:  sc_res = shamt_big ? '0 : (a >> shamt);
            OP_SRA:  sc_res = shamt_big ? {N{a[N-1]}} : sra_v;
            OP_ADD: begin
                sc_res = sum_v;
                sc_ovf = (a[N-1] == b[N-1]) && (sum_v[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sc_res = diff_v;
                sc_ovf = (a[N-1] == ~b[N-1]) && (diff_v[N-1] != a[N-1]);
            end
            OP_SLT:  sc_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res = {{(N-1){1'b0}}, (a < b)};
            default: sc_res = '0;
        endcase
    end

    // hi:lo is the product (multiplier shifts out of lo) or remainder:quotient.
    // A zero divisor always "fits", giving all-ones quotient and remainder = a.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + ({1'b0, a_q} & {(N+1){lo_q[0]}});
        div_shift = {hi_q, lo_q[N-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_sub   = div_shift[N-1:0] - b_q;
        if (op_is_div) begin
            step_hi = div_ge ? div_sub : div_shift[N-1:0];
            step_lo = {lo_q[N-2:0], div_ge};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], lo_q[N-1:1]};
        end
        mc_res = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? step_hi : step_lo;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        equal_d    = equal_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            op_d  = control;
            cnt_d = '0;
            if (in_is_mc) begin
                state_d = ST_BUSY;
                hi_d    = '0;
                lo_d    = in_is_mul ? b : a;
            end else begin
                state_d    = ST_DONE;
                result_d   = sc_res;
                overflow_d = sc_ovf;
                zero_d     = (sc_res == '0);
                equal_d    = (a == b);
            end
        end else if (state_q == ST_BUSY) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + S'(1);
            if (cnt_q == CNT_LAST) begin
                state_d    = ST_DONE;
                result_d   = mc_res;
                overflow_d = 1'b0;
                zero_d     = (mc_res == '0);
                equal_d    = (a_q == b_q);
            end
        end else if (consume) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            equal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            equal_q    <= equal_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign equal    = equal_q;

endmodule
